// File: rtl/adc_i2c_pkg.sv
// adc_i2c_pkg: shared types and constants for the ADC I2C sampler.
//   byte_state_t - byte-level transaction FSM states
//   bit_cmd_t    - single-bit bus operations issued to the bit engine
//   bit_levels() - pad enables {scl_oe, sda_oe} for a command in a quarter phase
package adc_i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_TX_BYTE,
    ST_RX_ACK,
    ST_RX_BYTE,
    ST_TX_ACK,
    ST_STOP
  } byte_state_t;

  typedef enum logic [1:0] {
    CMD_START,
    CMD_STOP,
    CMD_WR,
    CMD_RD
  } bit_cmd_t;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;
  localparam logic ACK      = 1'b0;
  localparam logic NACK     = 1'b1;

  // Returns {scl_oe, sda_oe}; 1 pulls the line low.
  // START: both released for q0/q1, SDA falls in q2 with SCL high, SCL low in q3.
  // STOP : SDA low, SCL released in q1/q2, SDA released with SCL high in q3.
  // WR/RD: SCL low q0, high q1/q2, low q3; SDA holds the bit for all four.
  function automatic logic [1:0] bit_levels(input bit_cmd_t cmd,
                                            input logic     wr_bit,
                                            input logic [1:0] phase);
    logic [1:0] lv;
    lv = 2'b00;
    case (cmd)
      CMD_START: lv = (phase == 2'd2) ? 2'b01 : (phase == 2'd3) ? 2'b11 : 2'b00;
      CMD_STOP:  lv = (phase == 2'd0) ? 2'b11 : (phase == 2'd3) ? 2'b00 : 2'b01;
      CMD_WR:    lv = {(phase == 2'd0 || phase == 2'd3), ~wr_bit};
      CMD_RD:    lv = {(phase == 2'd0 || phase == 2'd3), 1'b0};
      default:   lv = 2'b00;
    endcase
    return lv;
  endfunction

endpackage

// File: rtl/adc_i2c_sampler_bit_engine.sv
// i2c_bit_engine: executes one I2C bit-level command as four quarter phases.
//   clk, rst        - clock, synchronous active-high reset
//   cmd, cmd_valid  - command to run; accepted only while idle
//   wr_bit          - data bit for CMD_WR (1 = release SDA)
//   sda_i, scl_i    - pin levels
//   rd_bit          - SDA level sampled at the end of q2
//   rd_valid        - one-cycle strobe after rd_bit is captured
//   done            - one-cycle strobe in the last cycle of q3
//   sda_oe, scl_oe  - 1 pulls the line low
// Between commands the pads keep their q3 levels, so SCL stays low inside a
// transaction and both lines are released after a STOP.
module i2c_bit_engine
  import adc_i2c_pkg::*;
#(
  parameter int unsigned SCL_DIV = 63
) (
  input  logic     clk,
  input  logic     rst,
  input  bit_cmd_t cmd,
  input  logic     cmd_valid,
  input  logic     wr_bit,
  input  logic     sda_i,
  input  logic     scl_i,
  output logic     rd_bit,
  output logic     rd_valid,
  output logic     done,
  output logic     sda_oe,
  output logic     scl_oe
);

  localparam int unsigned CW = (SCL_DIV > 1) ? $clog2(SCL_DIV) : 1;

  logic          active;
  logic [1:0]    phase;
  logic [CW-1:0] cnt;
  bit_cmd_t      cmd_q;
  logic          wr_q;
  logic          stretch;
  logic          qtick;

  // A slave holding SCL low after we released it freezes divider and phase.
  assign stretch = active && (phase == 2'd1 || phase == 2'd2) && !scl_oe && !scl_i;
  assign qtick   = active && !stretch && (cnt == CW'(SCL_DIV - 1));
  assign done    = qtick && (phase == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      active   <= 1'b0;
      phase    <= '0;
      cnt      <= '0;
      cmd_q    <= CMD_STOP;
      wr_q     <= 1'b1;
      rd_bit   <= 1'b1;
      rd_valid <= 1'b0;
      sda_oe   <= 1'b0;
      scl_oe   <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (!active) begin
        if (cmd_valid) begin
          active           <= 1'b1;
          phase            <= '0;
          cnt              <= '0;
          cmd_q            <= cmd;
          wr_q             <= wr_bit;
          {scl_oe, sda_oe} <= bit_levels(cmd, wr_bit, 2'd0);
        end
      end else if (!stretch) begin
        if (qtick) begin
          cnt <= '0;
          if (phase == 2'd2) begin
            rd_bit   <= sda_i;
            rd_valid <= 1'b1;
          end
          if (phase == 2'd3) begin
            active <= 1'b0;
          end else begin
            phase            <= phase + 2'd1;
            {scl_oe, sda_oe} <= bit_levels(cmd_q, wr_q, phase + 2'd1);
          end
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/adc_i2c_sampler.sv
// adc_i2c_sampler: I2C master that writes CFG_BYTE to the ADC once, then reads
// one 12-bit sample (two bytes, low nibble of the first + second byte) per
// sample period.
//   clk, rst   - clock, synchronous active-high reset
//   en         - sampling enable (sample timer held at 0 while low)
//   sda_i/scl_i- pin levels; sda_oe/scl_oe - 1 pulls the line low
//   adc_data   - last valid sample; adc_valid - one-cycle update strobe
//   busy       - transaction in progress
//   ack_err    - one-cycle strobe on any slave NACK
//   overrun    - sticky: sample tick while a request was still pending
module adc_i2c_sampler
  import adc_i2c_pkg::*;
#(
  parameter int unsigned SCL_DIV    = 63,
  parameter int unsigned SAMPLE_DIV = 12500,
  parameter logic [6:0]  DEV_ADDR   = 7'h28,
  parameter logic [7:0]  CFG_BYTE   = 8'h10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        sda_i,
  output logic        sda_oe,
  input  logic        scl_i,
  output logic        scl_oe,
  output logic [11:0] adc_data,
  output logic        adc_valid,
  output logic        busy,
  output logic        ack_err,
  output logic        overrun
);

  localparam int unsigned TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  byte_state_t   state, state_n;
  logic          issue, issue_n;
  logic [TW-1:0] scnt;
  logic          tick;
  logic          pending;
  logic          consume;
  logic [2:0]    bit_cnt;
  logic [7:0]    tx_sr;
  logic [7:0]    rx_sr;
  logic [7:0]    msb_q;
  logic          byte_idx;
  logic          rw_q;
  logic          nack_seen;
  logic          cfg_done;

  bit_cmd_t      cmd;
  logic          wr_bit;
  logic          rd_bit;
  logic          rd_valid;
  logic          done;

  i2c_bit_engine #(.SCL_DIV(SCL_DIV)) u_bit (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cmd),
    .cmd_valid (issue),
    .wr_bit    (wr_bit),
    .sda_i     (sda_i),
    .scl_i     (scl_i),
    .rd_bit    (rd_bit),
    .rd_valid  (rd_valid),
    .done      (done),
    .sda_oe    (sda_oe),
    .scl_oe    (scl_oe)
  );

  assign busy    = (state != ST_IDLE);
  assign tick    = en && (scnt == TW'(SAMPLE_DIV - 1));
  assign consume = (state == ST_IDLE) && pending;

  // Sample timer and request bookkeeping. A tick coinciding with consumption
  // simply re-arms pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      scnt    <= '0;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (!en || tick) scnt <= '0;
      else             scnt <= scnt + TW'(1);
      pending <= (pending && !consume) || tick;
      if (tick && pending && !consume) overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      issue <= 1'b0;
    end else begin
      state <= state_n;
      issue <= issue_n;
    end
  end

  // Each completed bit launches the next command one cycle later via issue.
  always_comb begin
    state_n = state;
    issue_n = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pending) begin
          state_n = ST_START;
          issue_n = 1'b1;
        end
      end
      ST_START: begin
        if (done) begin
          state_n = ST_TX_BYTE;
          issue_n = 1'b1;
        end
      end
      ST_TX_BYTE: begin
        if (done) begin
          state_n = (bit_cnt == 3'd0) ? ST_RX_ACK : ST_TX_BYTE;
          issue_n = 1'b1;
        end
      end
      ST_RX_ACK: begin
        if (done) begin
          issue_n = 1'b1;
          if (rd_bit == NACK)        state_n = ST_STOP;
          else if (rw_q == RW_READ)  state_n = ST_RX_BYTE;
          else if (!byte_idx)        state_n = ST_TX_BYTE;
          else                       state_n = ST_STOP;
        end
      end
      ST_RX_BYTE: begin
        if (done) begin
          state_n = (bit_cnt == 3'd0) ? ST_TX_ACK : ST_RX_BYTE;
          issue_n = 1'b1;
        end
      end
      ST_TX_ACK: begin
        if (done) begin
          state_n = byte_idx ? ST_STOP : ST_RX_BYTE;
          issue_n = 1'b1;
        end
      end
      ST_STOP: begin
        if (done) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd    = CMD_STOP;
    wr_bit = 1'b1;
    case (state)
      ST_START:   cmd = CMD_START;
      ST_TX_BYTE: begin
        cmd    = CMD_WR;
        wr_bit = tx_sr[7];
      end
      ST_TX_ACK: begin
        cmd    = CMD_WR;
        wr_bit = byte_idx ? NACK : ACK;
      end
      ST_RX_ACK, ST_RX_BYTE: cmd = CMD_RD;
      default: ;
    endcase
  end

  // bit_cnt counts 7..0 and wraps back to 7, ready for the following byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      msb_q     <= '0;
      byte_idx  <= 1'b0;
      rw_q      <= RW_WRITE;
      nack_seen <= 1'b0;
      cfg_done  <= 1'b0;
      adc_data  <= '0;
      adc_valid <= 1'b0;
      ack_err   <= 1'b0;
    end else begin
      adc_valid <= 1'b0;
      ack_err   <= rd_valid && (state == ST_RX_ACK) && (rd_bit == NACK);
      case (state)
        ST_IDLE: begin
          if (pending) begin
            rw_q      <= cfg_done ? RW_READ : RW_WRITE;
            tx_sr     <= {DEV_ADDR, (cfg_done ? RW_READ : RW_WRITE)};
            byte_idx  <= 1'b0;
            nack_seen <= 1'b0;
            bit_cnt   <= 3'd7;
          end
        end
        ST_TX_BYTE: begin
          if (done) begin
            tx_sr   <= {tx_sr[6:0], 1'b0};
            bit_cnt <= bit_cnt - 3'd1;
          end
        end
        ST_RX_ACK: begin
          if (done) begin
            if (rd_bit == NACK) begin
              nack_seen <= 1'b1;
            end else if (rw_q == RW_WRITE && !byte_idx) begin
              tx_sr    <= CFG_BYTE;
              byte_idx <= 1'b1;
            end
          end
        end
        ST_RX_BYTE: begin
          if (done) begin
            rx_sr   <= {rx_sr[6:0], rd_bit};
            bit_cnt <= bit_cnt - 3'd1;
          end
        end
        ST_TX_ACK: begin
          if (done && !byte_idx) begin
            msb_q    <= rx_sr;
            byte_idx <= 1'b1;
          end
        end
        ST_STOP: begin
          if (done && !nack_seen) begin
            if (rw_q == RW_READ) begin
              adc_data  <= {msb_q[3:0], rx_sr};
              adc_valid <= 1'b1;
            end else begin
              cfg_done <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/adc_i2c_sampler.md
Name: adc_i2c_sampler

Overview:
- I2C master that configures the board ADC once, then reads one 12-bit sample per sample period.
- Sits between the open-drain SDA/SCL pads and the audio front end; feeds adc_data/adc_valid to feature extraction.
- The pads are tri-stated at top level; this block only drives low-enables and samples the pin inputs.

Parameters:
- SCL_DIV, 63: clk cycles per SCL quarter-bit (100 MHz -> ~397 kHz SCL).
- SAMPLE_DIV, 12500: clk cycles per sample request (100 MHz -> 8 kHz).
- DEV_ADDR, 7'h28: 7-bit ADC slave address.
- CFG_BYTE, 8'h10: config byte written after reset (channel 0 only).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  sampling enable.
- sda_i  in  1  SDA pin level.
- sda_oe  out  1  1 = pull SDA low, 0 = release.
- scl_i  in  1  SCL pin level (used for clock stretching).
- scl_oe  out  1  1 = pull SCL low, 0 = release.
- adc_data  out  12  last valid sample, unsigned.
- adc_valid  out  1  one-cycle strobe when adc_data updates.
- busy  out  1  I2C transaction in progress.
- ack_err  out  1  one-cycle strobe on any slave NACK.
- overrun  out  1  sticky: a sample tick arrived while one was already pending.

Behaviour:
- Reset: sda_oe=0, scl_oe=0, adc_data=0, adc_valid=0, busy=0, ack_err=0, overrun=0, cfg_done=0, timers=0, FSM=IDLE. Reset mid-transaction releases both lines on the next edge. No bus-recovery sequence is issued.
- Sample timer: counts 0..SAMPLE_DIV-1 while en=1 and is held at 0 while en=0. On wrap it sets pending. If pending is already set, it sets overrun instead.
- Quarter tick: divider pulses every SCL_DIV cycles during a transaction. Each bit takes 4 quarters:
  - q0: SCL low, set SDA.
  - q1: release SCL.
  - q2: SCL high, sample sda_i.
  - q3: pull SCL low.
- Clock stretching: in q1/q2, if scl_oe=0 and scl_i=0, the divider and phase freeze.
- Byte FSM states: IDLE, START, TX_BYTE, RX_ACK, RX_BYTE, TX_ACK, STOP.
- IDLE -> START when pending=1. Consumes pending; busy=1 from START until STOP completes.
- START: SDA falls while SCL is high (2 quarters), then SCL goes low.
- If cfg_done=0, the transaction is a write:
  - Send addr+W, RX_ACK, send CFG_BYTE, RX_ACK, STOP.
  - On success cfg_done=1, no adc_valid.
- If cfg_done=1, the transaction is a read:
  - Send addr+R, RX_ACK.
  - RX_BYTE (MSB), then TX_ACK with master ACK (SDA low).
  - RX_BYTE (LSB), then TX_ACK with master NACK (SDA released).
  - STOP.
- Bytes are shifted MSB first. Bits are sampled at q2.
- STOP: SDA low, release SCL, then release SDA while SCL is high.
- In the cycle the STOP completes: adc_data = {msb[3:0], lsb[7:0]}, adc_valid=1; bits msb[7:4] are ignored. busy falls the same cycle.
- NACK in any RX_ACK:
  - ack_err pulses one cycle at q2; the FSM goes straight to STOP.
  - No adc_valid; adc_data is held; cfg_done is unchanged.
  - A failed config is retried on the next tick.
- en falling mid-transaction: the current transaction completes normally and the FSM returns to IDLE.
- A tick and a transaction ending in the same cycle: pending is set, and START begins on the next cycle.
- adc_valid and ack_err are never high in the same cycle.

Decomposition:
- Package adc_i2c_pkg holds:
  - enum byte_state_t (the 7 states above);
  - enum bit_cmd_t (CMD_START, CMD_STOP, CMD_WR, CMD_RD);
  - localparams for the R/W bit values and ACK=0 / NACK=1.
- Sub-module i2c_bit_engine:
  - inputs: cmd, cmd_valid, wr_bit;
  - outputs: rd_bit, done, sda_oe, scl_oe;
  - owns the quarter divider, the 4-phase bit sequencing and clock stretching.
- The top module owns the sample timer, the byte FSM, the shift registers and the output registers.

Test Plan:
(Bench parameters SCL_DIV=4, SAMPLE_DIV=1500; open-drain slave model at 7'h28.)
- Reset, en=1 -> first transaction is a write: bytes 0x50 and 0x10, each ACKed; STOP; no adc_valid; second transaction is a read starting with byte 0x51.
- Slave returns 0x0A,0xBC -> adc_valid single pulse after STOP, adc_data=12'hABC. Slave returns 0xF0,0x01 -> adc_data=12'h001.
- Slave NACKs addr+R -> ack_err pulse, STOP follows, no adc_valid, adc_data keeps 12'hABC, next tick retries and succeeds.
- Slave stretches SCL 50 cycles on the MSB bit 3 -> scl_oe/sda_oe frozen during the stretch, correct data still captured, overrun stays 0.
- SAMPLE_DIV=100 -> overrun sets within 2 periods and stays 1; rst mid-RX_BYTE -> sda_oe=scl_oe=0 next cycle, all outputs at reset values.
- en deasserted during LSB byte -> transaction finishes with adc_valid, busy=0 afterwards, no further START while en=0.
